// File: rtl/timer1_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : timer1_access_controller_if
// Description : CPU I/O bus bundle between the bus decoder (master) and the
//               Timer/Counter1 access controller (slave).
//                 io_addr  : 6-bit I/O address
//                 io_wdata : write data
//                 io_we    : one-cycle write strobe
//                 io_re    : one-cycle read strobe
//                 io_rdata : registered read data, one cycle after io_re
// Revision    : 1.0  initial release
// ============================================================================
interface timer1_access_controller_if;
    logic [5:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_we;
    logic       io_re;
    logic [7:0] io_rdata;

    modport master (
        output io_addr,
        output io_wdata,
        output io_we,
        output io_re,
        input  io_rdata
    );

    modport slave (
        input  io_addr,
        input  io_wdata,
        input  io_we,
        input  io_re,
        output io_rdata
    );
endinterface
`default_nettype wire

// File: rtl/timer1_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer1_access_controller
// Description : Sequences CPU I/O accesses to the 16-bit Timer/Counter1
//               datapath: shared TEMP byte for atomic TCNT1/OCR1A access,
//               TCCR1B clock-select prescaler producing the count tick, and
//               the TIFR/TIMSK flag and interrupt logic.
// Ports       : sysClock        - system clock, rising edge
//               nReset          - asynchronous active-low reset
//               bus             - CPU I/O bus (slave modport)
//               tcnt_in         - current TCNT1 value from datapath
//               tcnt_load       - one-cycle preload strobe to datapath
//               tcnt_load_value - preload value, valid while tcnt_load=1
//               ocr_value       - committed OCR1A value
//               count_tick      - one-cycle count-enable pulse
//               ocf_event       - compare-match pulse from datapath
//               tov_event       - overflow pulse from datapath
//               tifr            - flag register (bit3 OCF1A, bit2 TOV1)
//               irq_compa       - OCF1A & OCIE1A
//               irq_ovf         - TOV1 & TOIE1
// Revision    : 1.0  initial release
// ============================================================================
module timer1_access_controller #(
    parameter logic [5:0] ADDR_OCR1AL = 6'h2A,
    parameter logic [5:0] ADDR_OCR1AH = 6'h2B,
    parameter logic [5:0] ADDR_TCNT1L = 6'h2C,
    parameter logic [5:0] ADDR_TCNT1H = 6'h2D,
    parameter logic [5:0] ADDR_TCCR1B = 6'h2E,
    parameter logic [5:0] ADDR_TIFR   = 6'h38,
    parameter logic [5:0] ADDR_TIMSK  = 6'h39
) (
    input  wire                        sysClock,
    input  wire                        nReset,
    timer1_access_controller_if.slave  bus,
    input  wire  [15:0]                tcnt_in,
    output logic                       tcnt_load,
    output logic [15:0]                tcnt_load_value,
    output logic [15:0]                ocr_value,
    output logic                       count_tick,
    input  wire                        ocf_event,
    input  wire                        tov_event,
    output logic [7:0]                 tifr,
    output logic                       irq_compa,
    output logic                       irq_ovf
);

    logic [7:0]  r_temp;
    logic [15:0] r_ocr;
    logic [2:0]  r_cs;
    logic [9:0]  r_prescale;
    logic        r_ocf;
    logic        r_tov;
    logic        r_ocie;
    logic        r_toie;
    logic [7:0]  r_rdata;
    logic        r_load;
    logic [15:0] r_load_value;

    logic        w_wr;
    logic        w_rd;
    logic        w_cs_run;
    logic [9:0]  w_tick_mask;
    logic [7:0]  w_tifr;
    logic [7:0]  w_rd_mux;

    // A simultaneous write suppresses the read entirely.
    assign w_wr   = bus.io_we;
    assign w_rd   = bus.io_re & ~bus.io_we;
    assign w_tifr = {4'b0000, r_ocf, r_tov, 2'b00};

    // Tick fires when the low log2(N) prescaler bits are all ones; /1 uses
    // an empty mask so every running cycle ticks.
    always_comb begin
        w_cs_run    = 1'b1;
        w_tick_mask = 10'h000;
        case (r_cs)
            3'd1:    w_tick_mask = 10'h000;
            3'd2:    w_tick_mask = 10'h007;
            3'd3:    w_tick_mask = 10'h03F;
            3'd4:    w_tick_mask = 10'h0FF;
            3'd5:    w_tick_mask = 10'h3FF;
            default: w_cs_run    = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (bus.io_addr)
            ADDR_OCR1AL: w_rd_mux = r_ocr[7:0];
            ADDR_OCR1AH: w_rd_mux = r_ocr[15:8];
            ADDR_TCNT1L: w_rd_mux = tcnt_in[7:0];
            ADDR_TCNT1H: w_rd_mux = r_temp;
            ADDR_TCCR1B: w_rd_mux = {5'b00000, r_cs};
            ADDR_TIFR:   w_rd_mux = w_tifr;
            ADDR_TIMSK:  w_rd_mux = {3'b000, r_ocie, 1'b0, r_toie, 2'b00};
            default:     w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge sysClock or negedge nReset) begin
        if (!nReset) begin
            r_temp       <= 8'h00;
            r_ocr        <= 16'hFFFF;
            r_cs         <= 3'd0;
            r_prescale   <= 10'd0;
            r_ocf        <= 1'b0;
            r_tov        <= 1'b0;
            r_ocie       <= 1'b0;
            r_toie       <= 1'b0;
            r_rdata      <= 8'h00;
            r_load       <= 1'b0;
            r_load_value <= 16'h0000;
        end else begin
            r_load <= w_wr && (bus.io_addr == ADDR_TCNT1L);
            if (w_wr && (bus.io_addr == ADDR_TCNT1L)) begin
                r_load_value <= {r_temp, bus.io_wdata};
            end

            // TEMP is shared by both 16-bit pairs: high writes fill it, a
            // TCNT1L read latches the upper counter byte for a later high read.
            if (w_wr && ((bus.io_addr == ADDR_TCNT1H) || (bus.io_addr == ADDR_OCR1AH))) begin
                r_temp <= bus.io_wdata;
            end else if (w_rd && (bus.io_addr == ADDR_TCNT1L)) begin
                r_temp <= tcnt_in[15:8];
            end

            if (w_wr && (bus.io_addr == ADDR_OCR1AL)) begin
                r_ocr <= {r_temp, bus.io_wdata};
            end

            if (w_wr && (bus.io_addr == ADDR_TCCR1B)) begin
                r_cs       <= bus.io_wdata[2:0];
                r_prescale <= 10'd0;
            end else if (w_cs_run) begin
                r_prescale <= r_prescale + 10'd1;
            end else begin
                r_prescale <= 10'd0;
            end

            // Event set has priority over a same-cycle write-1-to-clear.
            r_ocf <= ocf_event | (r_ocf & ~(w_wr && (bus.io_addr == ADDR_TIFR) && bus.io_wdata[3]));
            r_tov <= tov_event | (r_tov & ~(w_wr && (bus.io_addr == ADDR_TIFR) && bus.io_wdata[2]));

            if (w_wr && (bus.io_addr == ADDR_TIMSK)) begin
                r_ocie <= bus.io_wdata[4];
                r_toie <= bus.io_wdata[2];
            end

            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // A preload cycle swallows the tick; the prescaler keeps running.
    assign count_tick      = w_cs_run && ((r_prescale & w_tick_mask) == w_tick_mask) && !r_load;
    assign tcnt_load       = r_load;
    assign tcnt_load_value = r_load_value;
    assign ocr_value       = r_ocr;
    assign tifr            = w_tifr;
    assign irq_compa       = r_ocf & r_ocie;
    assign irq_ovf         = r_tov & r_toie;
    assign bus.io_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_timer1_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer1_access_controller
// Description : Self-checking bench for timer1_access_controller. A
//               behavioural model tracks register contents and the number of
//               cycles since the last clock-select write; outputs are compared
//               every cycle, with literal expectations for key scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_timer1_access_controller;

    localparam logic [5:0] A_OCRL  = 6'h2A;
    localparam logic [5:0] A_OCRH  = 6'h2B;
    localparam logic [5:0] A_TCNTL = 6'h2C;
    localparam logic [5:0] A_TCNTH = 6'h2D;
    localparam logic [5:0] A_TCCR  = 6'h2E;
    localparam logic [5:0] A_TIFR  = 6'h38;
    localparam logic [5:0] A_TIMSK = 6'h39;

    logic        sysClock = 1'b0;
    logic        nReset;
    logic [15:0] tcnt_in;
    logic        ocf_event;
    logic        tov_event;
    logic        tcnt_load;
    logic [15:0] tcnt_load_value;
    logic [15:0] ocr_value;
    logic        count_tick;
    logic [7:0]  tifr;
    logic        irq_compa;
    logic        irq_ovf;

    timer1_access_controller_if bus ();

    timer1_access_controller dut (
        .sysClock        (sysClock),
        .nReset          (nReset),
        .bus             (bus),
        .tcnt_in         (tcnt_in),
        .tcnt_load       (tcnt_load),
        .tcnt_load_value (tcnt_load_value),
        .ocr_value       (ocr_value),
        .count_tick      (count_tick),
        .ocf_event       (ocf_event),
        .tov_event       (tov_event),
        .tifr            (tifr),
        .irq_compa       (irq_compa),
        .irq_ovf         (irq_ovf)
    );

    always #5 sysClock = ~sysClock;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0]  m_temp;
    logic [15:0] m_ocr;
    logic [2:0]  m_cs;
    int          m_since;   // cycles elapsed since the clock-select write cycle
    logic        m_ocf, m_tov, m_ocie, m_toie;
    logic [7:0]  m_rdata;
    logic        m_load;
    logic [15:0] m_load_val;

    function automatic int divider(input logic [2:0] cs);
        case (cs)
            3'd1:    return 1;
            3'd2:    return 8;
            3'd3:    return 64;
            3'd4:    return 256;
            3'd5:    return 1024;
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_tick();
        int d;
        d = divider(m_cs);
        if (d == 0) return 1'b0;
        return ((m_since % d) == 0) && !m_load;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_temp = 8'h00; m_ocr = 16'hFFFF; m_cs = 3'd0; m_since = 0;
        m_ocf = 1'b0; m_tov = 1'b0; m_ocie = 1'b0; m_toie = 1'b0;
        m_rdata = 8'h00; m_load = 1'b0; m_load_val = 16'h0000;
    endtask

    // Applies the architectural rules for one clock edge using the inputs
    // currently on the bus.
    task automatic model_edge();
        logic [7:0]  o_temp;
        logic [15:0] o_ocr;
        logic        wr, rd;
        logic [5:0]  a;
        logic [7:0]  wd;
        o_temp = m_temp; o_ocr = m_ocr;
        wr = bus.io_we; rd = bus.io_re && !bus.io_we;
        a = bus.io_addr; wd = bus.io_wdata;
        if (rd) begin
            case (a)
                A_OCRL:  m_rdata = o_ocr[7:0];
                A_OCRH:  m_rdata = o_ocr[15:8];
                A_TCNTL: begin m_rdata = tcnt_in[7:0]; m_temp = tcnt_in[15:8]; end
                A_TCNTH: m_rdata = o_temp;
                A_TCCR:  m_rdata = {5'b0, m_cs};
                A_TIFR:  m_rdata = {4'b0, m_ocf, m_tov, 2'b0};
                A_TIMSK: m_rdata = {3'b0, m_ocie, 1'b0, m_toie, 2'b0};
                default: m_rdata = 8'h00;
            endcase
        end
        m_load = 1'b0;
        m_since++;
        if (wr) begin
            case (a)
                A_OCRH, A_TCNTH: m_temp = wd;
                A_TCNTL: begin m_load = 1'b1; m_load_val = {o_temp, wd}; end
                A_OCRL:  m_ocr = {o_temp, wd};
                A_TCCR:  begin m_cs = wd[2:0]; m_since = 1; end
                A_TIFR:  begin
                    if (wd[3]) m_ocf = 1'b0;
                    if (wd[2]) m_tov = 1'b0;
                end
                A_TIMSK: begin m_ocie = wd[4]; m_toie = wd[2]; end
                default: ;
            endcase
        end
        if (ocf_event) m_ocf = 1'b1;
        if (tov_event) m_tov = 1'b1;
    endtask

    task automatic check_all();
        chk("io_rdata",   bus.io_rdata, m_rdata);
        chk("tcnt_load",  tcnt_load,    m_load);
        if (m_load) chk("tcnt_load_value", tcnt_load_value, m_load_val);
        chk("ocr_value",  ocr_value,    m_ocr);
        chk("count_tick", count_tick,   exp_tick());
        chk("tifr",       tifr,         {4'b0, m_ocf, m_tov, 2'b0});
        chk("irq_compa",  irq_compa,    m_ocf & m_ocie);
        chk("irq_ovf",    irq_ovf,      m_tov & m_toie);
    endtask

    // Advance one cycle: model follows the edge, outputs compared mid-cycle,
    // then inputs return to idle.
    task automatic step();
        @(posedge sysClock);
        model_edge();
        @(negedge sysClock);
        check_all();
        bus.io_we = 1'b0; bus.io_re = 1'b0;
        ocf_event = 1'b0; tov_event = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.io_addr = a; bus.io_wdata = d; bus.io_we = 1'b1; bus.io_re = 1'b0;
        step();
    endtask

    task automatic rd(input logic [5:0] a);
        bus.io_addr = a; bus.io_wdata = 8'h00; bus.io_we = 1'b0; bus.io_re = 1'b1;
        step();
    endtask

    logic [5:0] addr_tab [10];

    initial begin
        addr_tab = '{A_OCRL, A_OCRH, A_TCNTL, A_TCNTH, A_TIFR, A_TIMSK, A_TCCR,
                     6'h00, 6'h3F, 6'h2F};
        nReset = 1'b0;
        bus.io_addr = 6'h00; bus.io_wdata = 8'h00; bus.io_we = 1'b0; bus.io_re = 1'b0;
        tcnt_in = 16'h0000; ocf_event = 1'b0; tov_event = 1'b0;
        model_reset();
        repeat (2) @(negedge sysClock);
        nReset = 1'b1;
        check_all();

        // Reset contents
        rd(A_OCRH);  chk("lit_ocrh_reset", bus.io_rdata, 8'hFF);
        rd(A_OCRL);  chk("lit_ocrl_reset", bus.io_rdata, 8'hFF);
        rd(A_TIFR);  chk("lit_tifr_reset", bus.io_rdata, 8'h00);
        repeat (5) begin step(); chk("lit_no_tick_cs0", count_tick, 1'b0); end

        // Atomic 16-bit TCNT1 write
        wr(A_TCNTH, 8'h12); chk("lit_high_no_load", tcnt_load, 1'b0);
        wr(A_TCNTL, 8'h34); chk("lit_load_pulse", tcnt_load, 1'b1);
        chk("lit_load_value", tcnt_load_value, 16'h1234);
        step(); chk("lit_load_single", tcnt_load, 1'b0);

        // Atomic 16-bit TCNT1 read through TEMP
        tcnt_in = 16'hABCD;
        rd(A_TCNTL); chk("lit_tcntl_read", bus.io_rdata, 8'hCD);
        tcnt_in = 16'h0000;
        rd(A_TCNTH); chk("lit_tcnth_temp", bus.io_rdata, 8'hAB);

        // Unmapped read returns zero
        rd(6'h00); chk("lit_unmapped_read", bus.io_rdata, 8'h00);

        // Prescaler /8
        wr(A_TCCR, 8'h02);
        for (int k = 1; k <= 28; k++) begin
            chk("lit_div8_tick", count_tick, (k % 8) == 0);
            step();
        end
        // Rewrite mid-period to /64: next tick 64 cycles after the rewrite
        wr(A_TCCR, 8'h03);
        for (int k = 1; k <= 64; k++) begin
            chk("lit_div64_tick", count_tick, k == 64);
            step();
        end
        wr(A_TCCR, 8'h06);
        repeat (20) begin chk("lit_cs6_no_tick", count_tick, 1'b0); step(); end

        // Load/tick collision at /1
        wr(A_TCCR, 8'h01);
        chk("lit_div1_tick", count_tick, 1'b1);
        wr(A_TCNTL, 8'h00);
        chk("lit_collision_load", tcnt_load, 1'b1);
        chk("lit_collision_tick", count_tick, 1'b0);
        step(); chk("lit_tick_resumes", count_tick, 1'b1);
        wr(A_TCCR, 8'h00);

        // Flags and interrupts
        wr(A_TIMSK, 8'h14);
        tov_event = 1'b1; step();
        chk("lit_tifr_tov", tifr, 8'h04); chk("lit_irq_ovf", irq_ovf, 1'b1);
        ocf_event = 1'b1; wr(A_TIFR, 8'h04);
        chk("lit_tifr_ocf", tifr, 8'h08); chk("lit_irq_ovf_clr", irq_ovf, 1'b0);
        chk("lit_irq_compa", irq_compa, 1'b1);
        ocf_event = 1'b1; wr(A_TIFR, 8'h08);
        chk("lit_set_wins", tifr, 8'h08);
        rd(A_TIFR); chk("lit_tifr_read", bus.io_rdata, 8'h08);
        chk("lit_read_noclear", tifr, 8'h08);
        wr(A_TIFR, 8'h08); chk("lit_w1c", tifr, 8'h00);

        // OCR1A via shared TEMP, then write-wins over read
        wr(A_TCNTH, 8'h5A); wr(A_OCRL, 8'hC3);
        chk("lit_ocr_shared_temp", ocr_value, 16'h5AC3);
        bus.io_addr = A_OCRH; bus.io_wdata = 8'h77; bus.io_we = 1'b1; bus.io_re = 1'b1;
        step(); chk("lit_write_wins", bus.io_rdata, 8'h08);

        // Reset between high and low write loses TEMP
        wr(A_TCNTH, 8'h55);
        nReset = 1'b0;
        @(posedge sysClock);
        @(negedge sysClock);
        nReset = 1'b1;
        model_reset();
        check_all();
        chk("lit_ocr_after_reset", ocr_value, 16'hFFFF);
        wr(A_TCNTL, 8'h77); chk("lit_temp_lost", tcnt_load_value, 16'h0077);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            bus.io_we    = (r < 25);
            bus.io_re    = (r >= 20) && (r < 50);
            bus.io_addr  = addr_tab[$urandom_range(0, 9)];
            bus.io_wdata = 8'($urandom);
            tcnt_in      = 16'($urandom);
            ocf_event    = ($urandom_range(0, 7) == 0);
            tov_event    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer1_access_controller.md
Name: timer1_access_controller

Overview:
Controller that sequences CPU I/O accesses to the 16-bit Timer/Counter1 datapath. It implements the shared TEMP byte for atomic 16-bit TCNT1/OCR1A reads and writes, and the TCCR1B clock-select prescaler that generates the count tick. It also holds the TIFR/TIMSK flag and interrupt logic (set-by-event, write-1-to-clear). It sits between the I/O bus decoder and the 16-bit timer datapath and drives that datapath's preload, compare value and count tick.

Parameters:
ADDR_OCR1AL, 6'h2A, I/O address of OCR1A low byte
ADDR_OCR1AH, 6'h2B, I/O address of OCR1A high byte
ADDR_TCNT1L, 6'h2C, I/O address of TCNT1 low byte
ADDR_TCNT1H, 6'h2D, I/O address of TCNT1 high byte
ADDR_TCCR1B, 6'h2E, I/O address of clock-select register
ADDR_TIFR, 6'h38, I/O address of flag register
ADDR_TIMSK, 6'h39, I/O address of mask register

Ports:
sysClock  in  1  system clock; all state on rising edge
nReset  in  1  asynchronous active-low reset
io_addr  in  6  I/O address
io_wdata  in  8  write data
io_we  in  1  write strobe, one cycle per access
io_re  in  1  read strobe, one cycle per access
io_rdata  out  8  read data, registered
tcnt_in  in  16  current TCNT1 value from datapath
tcnt_load  out  1  one-cycle preload strobe to datapath
tcnt_load_value  out  16  preload value, valid while tcnt_load=1
ocr_value  out  16  committed OCR1A value
count_tick  out  1  one-cycle count-enable pulse
ocf_event  in  1  compare-match pulse from datapath
tov_event  in  1  overflow pulse from datapath
tifr  out  8  flag register (bit3 OCF1A, bit2 TOV1, others 0)
irq_compa  out  1  OCF1A & OCIE1A
irq_ovf  out  1  TOV1 & TOIE1

Behaviour:
- Reset (async, nReset=0): TEMP=0, ocr_value=16'hFFFF, CS=0, prescaler counter=0, TIFR=0, TIMSK=0, io_rdata=0, tcnt_load=0, count_tick=0, irqs=0.
- Simultaneous io_we and io_re: write wins and the read is ignored. Writes and reads to unmapped addresses: writes are ignored, and reads return 8'h00 one cycle later.
- 16-bit write rule:
  - A write to TCNT1H or OCR1AH loads TEMP only.
  - A write to TCNT1L asserts tcnt_load for exactly the next cycle, with tcnt_load_value={TEMP,wdata}.
  - A write to OCR1AL updates ocr_value={TEMP,wdata} at that edge.
  - TEMP is shared between both register pairs. A high write to one pair followed by a low write to the other commits the TEMP from the last high write.
- 16-bit read rule:
  - A read of TCNT1L gives io_rdata=tcnt_in[7:0] on the next cycle and, at the same edge, TEMP<=tcnt_in[15:8].
  - A read of TCNT1H returns TEMP.
  - A read of OCR1AL/H returns ocr_value bytes directly; TEMP is untouched.
- io_rdata latency is 1 cycle. io_rdata holds its value when io_re=0.
- TCCR1B: bits[2:0]=CS; other bits read 0.
  - Divider by CS: 0 = stopped, no ticks. 1 = /1, tick every cycle. 2 = /8. 3 = /64. 4 = /256. 5 = /1024. 6 and 7 are treated as stopped (no external clock).
  - A 10-bit free-running prescaler counter increments each cycle while CS is in 1..5. count_tick=1 in the cycle the counter's low log2(N) bits are all 1, giving the first tick N cycles after the write.
  - Any TCCR1B write clears the prescaler counter to 0.
  - CS=0, 6 or 7 holds the counter at 0.
- Load/tick collision: count_tick is forced to 0 in any cycle where tcnt_load=1. The preload wins and the tick is lost; the prescaler counter itself still advances.
- TIFR:
  - ocf_event sets bit3 and tov_event sets bit2, at the clock edge.
  - Writing TIFR with a 1 in bit3 or bit2 clears that bit (W1C); writing 0 has no effect.
  - Event and clear in the same cycle on the same bit: the set wins.
  - Reading TIFR returns the flags and does not clear them.
- TIMSK: bit4 OCIE1A, bit2 TOIE1; other bits read 0. irq_compa and irq_ovf are combinational AND of flag and enable.
- Reset asserted mid-operation (e.g. between a high and low write): TEMP is lost. A subsequent low write alone commits {8'h00,wdata}.

Test Plan:
- Reset, then read OCR1AH/L and TIFR -> io_rdata 8'hFF, 8'hFF, 8'h00; count_tick never pulses while CS=0.
- Write TCNT1H=8'h12, then TCNT1L=8'h34 -> single tcnt_load pulse, tcnt_load_value=16'h1234; a high write alone produces no load.
- tcnt_in=16'hABCD: read TCNT1L -> 8'hCD. Change tcnt_in to 16'h0000, read TCNT1H -> 8'hAB (TEMP atomicity).
- Write CS=2 -> count_tick pulses at cycles 8, 16, 24 after the write. Rewrite CS=3 mid-period -> next tick 64 cycles after the rewrite. CS=6 -> no ticks.
- CS=1 with TCNT1L write -> count_tick low exactly in the tcnt_load cycle and high otherwise.
- TIMSK=8'h14. Pulse tov_event -> TIFR=8'h04 and irq_ovf=1. Write TIFR=8'h04 with ocf_event in the same cycle -> TIFR=8'h08, irq_ovf=0, irq_compa=1. Write TIFR=8'h08 together with ocf_event -> bit3 stays set.
